// File: rtl/obstacle_three_ctrl.sv
// obstacle_three_ctrl
//   Motion/spawn controller for the obstacle-three sprite source. Once per
//   frame it scrolls the obstacle left. When the obstacle leaves the screen
//   it is hidden. After a delay it respawns at a pseudo-random height. The
//   block also cycles the colour and animation id, freezes on a collision,
//   and flags pass events to the score logic.
//
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   frame_tick     one-clk pulse at the start of vertical blank
//   start          one-clk pulse, launches the obstacle from IDLE
//   restart        one-clk pulse, returns to IDLE from any state
//   pause          level, masks frame_tick while high
//   hit            one-clk collision pulse, honoured only while moving
//   speed[2:0]     pixels per frame (0 behaves as 1)
//   x0, y0 [10:0]  registered sprite origin
//   ctrl[4:0]      {colour[1:0], auto=0, sprite_id[1:0]}
//   active         high while moving
//   passed         one-clk pulse when the obstacle exits the left edge
//   frozen         high while halted after a hit
module obstacle_three_ctrl #(
  parameter int unsigned X_START        = 640,
  parameter int unsigned X_HIDE         = 2047,
  parameter int unsigned Y_MIN          = 300,
  parameter int unsigned RESPAWN_FRAMES = 30,
  parameter int unsigned ANI_FRAMES     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        restart,
  input  logic        pause,
  input  logic        hit,
  input  logic [2:0]  speed,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [4:0]  ctrl,
  output logic        active,
  output logic        passed,
  output logic        frozen
);

  localparam logic [10:0] XS     = 11'(X_START);
  localparam logic [10:0] XH     = 11'(X_HIDE);
  localparam logic [10:0] YM     = 11'(Y_MIN);
  localparam logic [7:0]  RF_END = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0]  AF_END = 8'(ANI_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [10:0] x_q, x_n, y_q, y_n;
  logic [1:0]  colour_q, colour_n, id_q, id_n;
  logic [7:0]  lfsr_q, lfsr_n;
  logic [7:0]  frame_q, frame_n, ani_q, ani_n;
  logic        passed_q, passed_n;

  logic        tick_acc;
  logic        do_spawn;
  logic [10:0] spd;
  logic        lfsr_fb;

  assign tick_acc = frame_tick & ~pause;
  assign spd      = (speed == 3'd0) ? 11'd1 : {8'd0, speed};
  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    state_n  = state;
    x_n      = x_q;
    y_n      = y_q;
    colour_n = colour_q;
    id_n     = id_q;
    frame_n  = frame_q;
    ani_n    = ani_q;
    passed_n = 1'b0;
    do_spawn = 1'b0;
    // The LFSR runs in every state, including across restart.
    lfsr_n   = tick_acc ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;

    if (restart) begin
      state_n  = IDLE;
      x_n      = XH;
      y_n      = YM;
      colour_n = '0;
      id_n     = '0;
      frame_n  = '0;
      ani_n    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          x_n = XH;
          if (start) begin
            do_spawn = 1'b1;
            colour_n = '0;
          end
        end
        MOVE: begin
          if (hit) begin
            state_n = HALT;
          end else if (tick_acc) begin
            if (ani_q == AF_END) begin
              ani_n = '0;
              id_n  = id_q + 2'd1;
            end else begin
              ani_n = ani_q + 8'd1;
            end
            if (x_q < spd) begin
              x_n      = XH;
              passed_n = 1'b1;
              frame_n  = '0;
              state_n  = WAIT;
            end else begin
              x_n = x_q - spd;
            end
          end
        end
        WAIT: begin
          if (tick_acc) begin
            if (frame_q == RF_END) begin
              do_spawn = 1'b1;
              colour_n = colour_q + 2'd1;
              frame_n  = '0;
            end else begin
              frame_n = frame_q + 8'd1;
            end
          end
        end
        HALT: ;
        default: state_n = IDLE;
      endcase

      // Spawn height uses the LFSR value from before this tick's advance.
      if (do_spawn) begin
        state_n = MOVE;
        x_n     = XS;
        y_n     = YM + {4'd0, lfsr_q[6:0]};
        id_n    = '0;
        ani_n   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      x_q      <= XH;
      y_q      <= YM;
      colour_q <= '0;
      id_q     <= '0;
      lfsr_q   <= 8'hA5;
      frame_q  <= '0;
      ani_q    <= '0;
      passed_q <= 1'b0;
    end else begin
      state    <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      colour_q <= colour_n;
      id_q     <= id_n;
      lfsr_q   <= lfsr_n;
      frame_q  <= frame_n;
      ani_q    <= ani_n;
      passed_q <= passed_n;
    end
  end

  assign x0     = x_q;
  assign y0     = y_q;
  assign ctrl   = {colour_q, 1'b0, id_q};
  assign active = (state == MOVE);
  assign frozen = (state == HALT);
  assign passed = passed_q;

endmodule

// File: tb/tb_obstacle_three_ctrl.sv
// Directed testbench for obstacle_three_ctrl. Expected values are computed
// by hand or from a small reference LFSR model of the spawn-height source.
module tb_obstacle_three_ctrl;

  logic        clk;
  logic        reset_n;
  logic        frame_tick;
  logic        start;
  logic        restart;
  logic        pause;
  logic        hit;
  logic [2:0]  speed;
  logic [10:0] x0;
  logic [10:0] y0;
  logic [4:0]  ctrl;
  logic        active;
  logic        passed;
  logic        frozen;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [7:0]  m_lfsr;
  logic [7:0]  m_pre;

  obstacle_three_ctrl #(
    .X_START(640),
    .X_HIDE(2047),
    .Y_MIN(300),
    .RESPAWN_FRAMES(30),
    .ANI_FRAMES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_tick(frame_tick),
    .start(start),
    .restart(restart),
    .pause(pause),
    .hit(hit),
    .speed(speed),
    .x0(x0),
    .y0(y0),
    .ctrl(ctrl),
    .active(active),
    .passed(passed),
    .frozen(frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [31:0] exp_y(input logic [7:0] v);
    return 32'd300 + {25'd0, v[6:0]};
  endfunction

  // One frame tick; returns just after the capturing edge, at a negedge.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    m_pre = m_lfsr;
    if (!pause) m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Run a full move at speed 7 (92 ticks to exit) and a 30-tick wait,
  // checking the pass pulse and the respawn.
  task automatic lap(input logic [1:0] colour_exp, input string tag);
    for (int i = 0; i < 91; i++) tick();
    check({tag, " x before exit"}, 32'(x0), 32'd3);
    tick();
    check({tag, " passed"}, 32'(passed), 32'd1);
    check({tag, " hidden"}, 32'(x0), 32'd2047);
    for (int i = 0; i < 30; i++) tick();
    check({tag, " respawn x0"}, 32'(x0), 32'd640);
    check({tag, " respawn y0"}, 32'(y0), exp_y(m_pre));
    check({tag, " colour"}, 32'(ctrl[4:3]), 32'(colour_exp));
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    m_lfsr = 8'hA5;
    m_pre = 8'hA5;
    reset_n = 1'b0;
    frame_tick = 1'b0;
    start = 1'b0;
    restart = 1'b0;
    pause = 1'b0;
    hit = 1'b0;
    speed = 3'd4;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("reset x0", 32'(x0), 32'd2047);
    check("reset y0", 32'(y0), 32'd300);
    check("reset ctrl", 32'(ctrl), 32'd0);
    check("reset active", 32'(active), 32'd0);
    check("reset passed", 32'(passed), 32'd0);
    check("reset frozen", 32'(frozen), 32'd0);

    pulse_start();
    check("spawn x0", 32'(x0), 32'd640);
    check("spawn y0", 32'(y0), 32'd337);
    check("spawn ctrl", 32'(ctrl), 32'd0);
    check("spawn active", 32'(active), 32'd1);

    // Speed 4: 160 ticks reach x0=0; sprite id steps every 8 ticks.
    for (int i = 1; i <= 160; i++) begin
      tick();
      if (i == 7)  check("id before step", 32'(ctrl[1:0]), 32'd0);
      if (i == 8)  check("id step 1", 32'(ctrl[1:0]), 32'd1);
      if (i == 24) check("id step 3", 32'(ctrl[1:0]), 32'd3);
      if (i == 32) check("id wrap", 32'(ctrl[1:0]), 32'd0);
    end
    check("x0 at zero", 32'(x0), 32'd0);
    tick();
    check("exit x0", 32'(x0), 32'd2047);
    check("exit passed", 32'(passed), 32'd1);
    check("exit active", 32'(active), 32'd0);
    @(negedge clk);
    check("passed one clk", 32'(passed), 32'd0);

    for (int i = 0; i < 29; i++) tick();
    check("no early spawn", 32'(x0), 32'd2047);
    check("wait active", 32'(active), 32'd0);
    tick();
    check("respawn x0", 32'(x0), 32'd640);
    check("respawn colour", 32'(ctrl[4:3]), 32'd1);
    check("respawn y0", 32'(y0), exp_y(m_pre));
    check("respawn id", 32'(ctrl[1:0]), 32'd0);

    speed = 3'd7;
    lap(2'd2, "lap2");
    lap(2'd3, "lap3");
    lap(2'd0, "lap4");

    // Pause masks ticks; speed 0 moves one pixel per frame.
    speed = 3'd0;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("paused x0", 32'(x0), 32'd640);
    pause = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("speed0 x0", 32'(x0), 32'd637);

    // Hit wins over a coincident tick.
    @(negedge clk);
    hit = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    frame_tick = 1'b0;
    m_lfsr = lfsr_step(m_lfsr);
    check("hit frozen", 32'(frozen), 32'd1);
    check("hit x0", 32'(x0), 32'd637);
    check("hit active", 32'(active), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    pulse_start();
    check("halt x0 hold", 32'(x0), 32'd637);
    check("halt frozen", 32'(frozen), 32'd1);
    pulse_restart();
    check("restart x0", 32'(x0), 32'd2047);
    check("restart ctrl", 32'(ctrl), 32'd0);
    check("restart frozen", 32'(frozen), 32'd0);
    check("restart y0", 32'(y0), 32'd300);

    // Spawn height reflects an LFSR that ignored the paused ticks.
    pulse_start();
    check("relaunch y0", 32'(y0), exp_y(m_lfsr));
    check("relaunch x0", 32'(x0), 32'd640);

    speed = 3'd7;
    for (int i = 0; i < 92; i++) tick();
    check("pre-reset passed", 32'(passed), 32'd1);
    check("pre-reset id", 32'(ctrl[1:0]), 32'd3);
    for (int i = 0; i < 5; i++) tick();

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async x0", 32'(x0), 32'd2047);
    check("async y0", 32'(y0), 32'd300);
    check("async ctrl", 32'(ctrl), 32'd0);
    check("async active", 32'(active), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_lfsr = 8'hA5;
    pulse_start();
    check("post-reset y0", 32'(y0), 32'd337);
    check("post-reset active", 32'(active), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_three_ctrl.md
Name: obstacle_three_ctrl

Overview:
- Motion/spawn controller that sits directly upstream of the obstacle-three sprite source.
- Drives that stage's sprite origin (x0, y0) and 5-bit sprite control word once per video frame.
- Scrolls the obstacle leftward at a programmable speed, hides it after it exits, and respawns it at a pseudo-random height after a programmable delay.
- Cycles body colour and animation id, freezes on collision, and reports pass events to the score logic.

Parameters:
- X_START, 640, x0 loaded at each spawn.
- X_HIDE, 2047, x0 value while hidden; keeps the sprite out of region for all visible x.
- Y_MIN, 300, base of the spawn height band. y0 = Y_MIN + lfsr[6:0], range Y_MIN..Y_MIN+127.
- RESPAWN_FRAMES, 30, frame ticks spent hidden before respawn (1..255).
- ANI_FRAMES, 8, frame ticks per animation id step (1..255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-clk pulse at start of vertical blank.
- start  in  1  one-clk pulse; launches the obstacle from IDLE.
- restart  in  1  one-clk pulse; returns the block to IDLE from any state.
- pause  in  1  level; while high, frame_tick is ignored.
- hit  in  1  one-clk collision pulse from collision logic.
- speed  in  3  pixels per frame; 0 is treated as 1.
- x0  out  11  sprite origin x (registered).
- y0  out  11  sprite origin y (registered).
- ctrl  out  5  [4:3] colour select, [2] auto (always 0), [1:0] sprite id.
- active  out  1  high in MOVE.
- passed  out  1  one-clk pulse when the obstacle exits the left edge.
- frozen  out  1  high in HALT.

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, x0=X_HIDE, y0=Y_MIN, ctrl=0, active=0, passed=0, frozen=0.
  - lfsr=8'hA5; frame and animation counters=0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting left. Advances only on accepted frame ticks (frame_tick & ~pause), in every state. Never reaches 0.
- spd = (speed==0) ? 1 : speed, zero-extended to 11 bits.
- Spawn action, applied in one clk:
  - x0 <= X_START; y0 <= Y_MIN + lfsr[6:0] (pre-advance value); sprite id <= 0; animation counter <= 0.
  - Next state is MOVE.
- IDLE:
  - x0 = X_HIDE.
  - start -> spawn, with colour select forced to 0.
- MOVE:
  - On an accepted tick, if x0 < spd: x0 <= X_HIDE, pulse passed for 1 clk, clear the frame counter, go to WAIT.
  - Otherwise x0 <= x0 - spd. No underflow is possible.
  - The animation counter increments on each accepted tick. At ANI_FRAMES-1 it clears and sprite id increments mod 4.
- WAIT:
  - The frame counter increments on each accepted tick.
  - The tick on which the counter reaches RESPAWN_FRAMES-1 triggers a spawn and colour select increments mod 4.
  - The counter clears on exit.
- HALT:
  - Entered from MOVE on hit. x0, y0 and ctrl hold; frozen=1.
  - Only restart exits.
- Priority within a clk: restart > hit > frame_tick. hit outside MOVE is ignored.
- start outside IDLE is ignored.
- restart leads to IDLE next clk. All outputs return to their reset values except lfsr, which keeps running. restart takes effect mid-move or mid-wait.
- Latency: outputs change on the clk edge after the triggering tick. They are stable for the remainder of the frame.

Test Plan:
- Reset, then start pulse -> next clk: x0=640, y0=337 (0xA5 & 0x7F = 37), ctrl=0, active=1.
- speed=4, 160 frame ticks -> x0=0. 161st tick -> x0=2047, passed high for exactly 1 clk, state WAIT, active=0.
- Continue with RESPAWN_FRAMES=30 -> no spawn after 29 ticks; 30th tick -> x0=640, ctrl[4:3]=01, y0=Y_MIN+lfsr[6:0] matching the reference model. Four respawns wrap colour select to 00.
- speed=0, pause held high for 10 ticks in MOVE -> x0 unchanged, lfsr unchanged. Release, then 3 ticks -> x0 decreases by 3. ctrl[1:0] increments every 8 ticks, wrapping 3->0.
- hit and frame_tick in the same clk during MOVE -> frozen=1, x0 unchanged. Later ticks and start have no effect. restart -> IDLE, x0=2047, ctrl=0.
- reset_n asserted mid-WAIT, asynchronously between clk edges -> outputs reach reset values immediately. After release, start spawns with y0=337.
